// File: rtl/clkdiv_pkg.sv
// Shared types and defaults for the multi-channel clock-enable generator.
// Lock/align FSM states and the reset divide ratio.
package clkdiv_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    ALIGN     = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam int DEF_DIV_C = 20;

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: shadow/active ratio, phase load, counter and
// registered enable/square outputs.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int DEF_DIV = DEF_DIV_C
) (
  input  logic             clk,
  input  logic             rst_n,
  input  state_t           state,
  input  state_t           state_n,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_div,
  input  logic [CNT_W-1:0] wr_phase,
  output logic             clk_en,
  output logic             clk_sq
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_DIV);

  logic [CNT_W-1:0] sh_div;
  logic [CNT_W-1:0] sh_ph;
  logic [CNT_W-1:0] act;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] src_div;
  logic [CNT_W-1:0] act_n;
  logic [CNT_W-1:0] cnt_n;
  logic             run_n;

  // A write landing on the wrap cycle is picked up at that wrap.
  assign src_div = wr_en ? wr_div : sh_div;
  assign run_n   = (state_n == RUN);

  always_comb begin
    act_n = act;
    cnt_n = cnt;
    unique case (state)
      WAIT_LOCK: act_n = src_div;
      ALIGN: begin
        act_n = sh_div;
        cnt_n = (sh_ph >= sh_div) ? '0 : sh_ph;
      end
      RUN: begin
        if (act == '0) begin
          cnt_n = '0;
          if (wr_en) act_n = wr_div;
        end else if (cnt >= act - ONE) begin
          cnt_n = '0;
          act_n = src_div;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_div <= DEF;
      sh_ph  <= '0;
      act    <= DEF;
      cnt    <= '0;
      clk_en <= 1'b0;
      clk_sq <= 1'b0;
    end else begin
      if (wr_en) begin
        sh_div <= wr_div;
        sh_ph  <= wr_phase;
      end
      act    <= act_n;
      cnt    <= cnt_n;
      clk_en <= run_n && (act_n != '0)
                && (cnt_n == act_n - ONE);
      clk_sq <= run_n && (cnt_n < (act_n >> 1));
    end
  end

endmodule

// File: rtl/clkdiv_multi_gen.sv
// Multi-channel clock-enable generator: lock synchroniser and filter,
// align FSM, config decode and NUM_CH divider channels.
module clkdiv_multi_gen
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 16,
  parameter int LOCK_FILT = 64,
  parameter int DEF_DIV   = DEF_DIV_C,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              pll_locked,
  input  logic              resync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_phase,
  output logic [NUM_CH-1:0] clk_en,
  output logic [NUM_CH-1:0] clk_sq,
  output logic              running
);

  localparam int FW = $clog2(LOCK_FILT + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILT - 1);
  localparam logic [FW-1:0] FILT_ONE  = FW'(1);

  logic          sync_q;
  logic          locked_s;
  logic [FW-1:0] filt;
  state_t        state;
  state_t        state_n;
  logic          wr;

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      sync_q   <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_q   <= pll_locked;
      locked_s <= sync_q;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      WAIT_LOCK:
        if (locked_s && filt == FILT_LAST) state_n = ALIGN;
      ALIGN: state_n = RUN;
      RUN: begin
        // Losing lock outranks a coincident resync.
        if (!locked_s)   state_n = WAIT_LOCK;
        else if (resync) state_n = ALIGN;
      end
      default: state_n = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state     <= WAIT_LOCK;
      filt      <= '0;
      running   <= 1'b0;
      cfg_ready <= 1'b0;
    end else begin
      state     <= state_n;
      filt      <= (state == WAIT_LOCK && locked_s)
                   ? filt + FILT_ONE : '0;
      running   <= (state_n == RUN);
      cfg_ready <= (state_n != ALIGN);
    end
  end

  assign wr = cfg_valid && cfg_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_en;
    assign wr_en = wr && (cfg_ch == CH_W'(i));

    clkdiv_chan #(
      .CNT_W  (CNT_W),
      .DEF_DIV(DEF_DIV)
    ) u_chan (
      .clk     (refclk),
      .rst_n   (rst_n),
      .state   (state),
      .state_n (state_n),
      .wr_en   (wr_en),
      .wr_div  (cfg_div),
      .wr_phase(cfg_phase),
      .clk_en  (clk_en[i]),
      .clk_sq  (clk_sq[i])
    );
  end

endmodule

// File: doc/clkdiv_multi_gen.md
# clkdiv_multi_gen

Parametrised multi-channel clock-enable generator that sits directly behind the PLL wrapper on its fastest output clock. It derives NUM_CH slower rates, for example 10 MHz from 200 MHz, as single-cycle enables and square waves in one clock domain. Each channel has a runtime-programmable divide ratio and phase. All outputs are held off until the PLL lock indication has been stable for a filter period, and are re-aligned on every lock or on request.

## Interface
Parameters:
- NUM_CH, 4: number of output channels (1..16).
- CNT_W, 16: width of the divide and phase counters.
- LOCK_FILT, 64: consecutive synced locked cycles required before running (≥1).
- DEF_DIV, 20: divide ratio loaded into every channel at reset.

Ports:
- refclk, in, 1: clock, the PLL fast output.
- rst_n, in, 1: reset. Synchronous, active-low.
- pll_locked, in, 1: PLL lock, asynchronous; 2-flop synchronised internally to locked_s.
- resync, in, 1: single-cycle pulse; forces re-alignment while running.
- cfg_valid, in, 1: configuration write request.
- cfg_ready, out, 1: configuration write accepted when high together with cfg_valid.
- cfg_ch, in, $clog2(NUM_CH) (minimum 1): target channel.
- cfg_div, in, CNT_W: divide ratio; 0 disables the channel.
- cfg_phase, in, CNT_W: counter start value applied at alignment.
- clk_en, out, NUM_CH: one-cycle enable per channel period.
- clk_sq, out, NUM_CH: square wave per channel.
- running, out, 1: high while the FSM is in RUN.

## Operation
- FSM states: WAIT_LOCK (reset state), ALIGN, RUN.
  - WAIT_LOCK: lock filter counter increments while locked_s=1 and clears to 0 whenever locked_s=0. After LOCK_FILT consecutive high samples, go to ALIGN.
  - ALIGN: lasts exactly 1 cycle. Every channel counter loads its phase value, or 0 if phase ≥ div. Next state is RUN.
  - RUN: locked_s=0 goes to WAIT_LOCK, with the filter cleared. resync=1 goes to ALIGN. If both are true in the same cycle, WAIT_LOCK wins.
- Channel counter, RUN only: counts 0..div-1 and wraps to 0. Counters are held outside RUN.
  - clk_en[i] = (cnt == div-1).
  - clk_sq[i] = (cnt < div>>1).
  - div=1: clk_en is constantly 1 and clk_sq is constantly 0.
  - div=0: both outputs are 0 and the counter is held at 0.
- Configuration:
  - Each channel has a shadow register pair (div, phase), reset to DEF_DIV and 0.
  - A write happens when cfg_valid && cfg_ready.
  - cfg_ch ≥ NUM_CH: the handshake completes and the data is discarded.
  - A div write in RUN becomes the active div at that channel's next wrap: the cycle after cnt == old div-1, the counter goes to 0 under the new div.
  - A write to a channel whose active div is 0 takes effect on the next cycle.
  - A phase write takes effect only at the next ALIGN.
- cfg_ready = (state != ALIGN) and is 0 during reset.

## Timing
- All outputs are registered. Reset values: clk_en=0, clk_sq=0, running=0, cfg_ready=0. FSM=WAIT_LOCK, filter=0, counters=0.
- pll_locked to locked_s: 2 cycles.
- First locked_s=1 at cycle t: ALIGN at t+LOCK_FILT, RUN and running=1 at t+LOCK_FILT+1.
- In the first RUN cycle, outputs reflect cnt=phase.
- locked_s falls at cycle u: state is WAIT_LOCK at u+1, and all clk_en/clk_sq/running are 0 at u+1.
- rst_n low mid-operation: all state returns to reset values on the next edge, and the shadow registers reload their defaults.
- Back-to-back cfg writes are accepted every cycle except in ALIGN.

## Structure
- Shared package clkdiv_pkg holds the FSM state enum (WAIT_LOCK/ALIGN/RUN) and the DEF_DIV default constant.
- One sub-module, clkdiv_chan: a single channel's counter, active/shadow div, phase load and output registers. It is instantiated NUM_CH times via generate.
- The top level holds the synchroniser, lock filter, FSM and config decode.

## Test plan
- Reset, then pll_locked=1 held with LOCK_FILT=64 and DEF_DIV=20: running rises 2+64+1 cycles after pll_locked. clk_en pulses every 20 cycles, and clk_sq is high 10 and low 10 cycles.
- Write ch1 div=7, phase=3 during WAIT_LOCK: the first clk_en[1] comes 3 cycles after RUN entry, then every 7 cycles. clk_sq[1] is high 3 and low 4 cycles.
- In RUN, write ch0 div=4 mid-period: the old 20-cycle period completes, then clk_en[0] has period 4 with no runt pulse.
- pll_locked glitches low for 1 cycle in WAIT_LOCK at filter=50: the filter restarts. In RUN, a drop gives all outputs 0 one cycle after locked_s falls, and re-lock repeats the full 64-cycle filter.
- div=0 and div=1 on ch2/ch3: outputs are 0/0 and 1/0 respectively. cfg_ch=NUM_CH write: the handshake completes and no channel changes.
- resync pulse and locked_s drop in the same cycle: the FSM enters WAIT_LOCK, not ALIGN. A lone resync gives cfg_ready=0 for exactly 1 cycle, and every counter restarts at its phase.
